debounce_pulse: RTL and testbench

- Upstream conditioning stage for the event counter. Takes a raw asynchronous input such as a push-button or sensor contact, synchronises it, and debounces it with a stability-timer FSM.
- Emits a single-cycle pulse per validated press. This pulse drives the counter's count-enable input directly.
- Also provides the debounced level, a release pulse, and a busy flag.

---
 rtl/debounce_pulse.sv | 242 ++++++++++++++++++++++++
 tb/tb_debounce_pulse.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/debounce_pulse.sv
// -----------------------------------------------------------------------------
// debounce_pulse
//
// Input conditioning stage for the event counter. A raw asynchronous contact
// input is synchronised and then debounced by a stability-timer FSM. Each
// validated press produces a single-cycle pulse that feeds the counter's
// count-enable directly. The block also provides the debounced level, a
// release pulse and a busy flag.
//
// Parameters
//   SYNC_STAGES   : synchroniser depth on din (>= 2)
//   STABLE_CYCLES : consecutive stable synchronised samples needed to accept
//                   a transition once it is first seen (>= 1)
//   CNT_BITS      : width of the stability and repeat counters; must satisfy
//                   2**CNT_BITS > max(STABLE_CYCLES, REPEAT_CYCLES)
//   REPEAT_CYCLES : auto-repeat period in cycles (>= 2), only meaningful when
//                   AUTO_REPEAT_EN is defined
//
// Build option
//   AUTO_REPEAT_EN : when defined, a held press re-issues `pulse` every
//                    REPEAT_CYCLES cycles after the level rises. When
//                    undefined, no repeat logic exists and each press gives
//                    exactly one pulse.
//
// Ports
//   clk   in  system clock, all flops on the rising edge
//   rst   in  asynchronous active-low reset, released synchronously to clk
//   din   in  raw asynchronous input, active-high
//   level out debounced level of din (registered)
//   pulse out one-cycle high per validated rising edge (registered)
//   rel   out one-cycle high per validated falling edge (registered)
//   busy  out high while a transition is being qualified
// -----------------------------------------------------------------------------
module debounce_pulse #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned CNT_BITS      = 8,
  parameter int unsigned REPEAT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic pulse,
  output logic rel,
  output logic busy
);

  // ---------------------------------------------------------------------------
  // Constants and configuration
  // ---------------------------------------------------------------------------
`ifdef AUTO_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  // Largest terminal count either counter must reach; REPEAT_CYCLES only
  // matters when the repeat logic is built.
  localparam int unsigned MAX_TERM =
    (REPEAT_ON && (REPEAT_CYCLES > STABLE_CYCLES)) ? REPEAT_CYCLES : STABLE_CYCLES;

  localparam bit PARAMS_OK =
    (SYNC_STAGES >= 2) &&
    (STABLE_CYCLES >= 1) &&
    (!REPEAT_ON || (REPEAT_CYCLES >= 2)) &&
    ((64'(1) << CNT_BITS) > 64'(MAX_TERM));

  localparam logic [CNT_BITS-1:0] CNT_ZERO    = '0;
  localparam logic [CNT_BITS-1:0] CNT_ONE     = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] STABLE_LAST = CNT_BITS'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  // NOTE: the synchroniser chain is reset along with the FSM so that a level
  // already present on din at reset release is seen as a fresh 0->1 edge
  // and goes through the full qualification like any other press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce FSM state
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] c_q, c_d;
  logic                level_q, level_d;
  logic                pulse_q, pulse_d;
  logic                rel_q, rel_d;

`ifdef AUTO_REPEAT_EN
  logic [CNT_BITS-1:0] r_q, r_d;
  localparam logic [CNT_BITS-1:0] REPEAT_LAST = CNT_BITS'(REPEAT_CYCLES - 1);
`endif

  // NOTE: every state element is updated with non-blocking assignments so all
  // flops sample the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE_LOW;
      c_q     <= CNT_ZERO;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      rel_q   <= rel_d;
    end
  end

`ifdef AUTO_REPEAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= CNT_ZERO;
    end else begin
      r_q <= r_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  // NOTE: every variable driven here gets a default before the case statement,
  // so no path can leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    level_d = level_q;
    pulse_d = 1'b0;
    rel_d   = 1'b0;
`ifdef AUTO_REPEAT_EN
    // The repeat counter only runs while resting in IDLE_HIGH; anywhere else
    // it is held at zero, which also gives the clear-on-entry behaviour.
    r_d     = CNT_ZERO;
`endif

    unique case (state_q)
      IDLE_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          c_d     = CNT_ZERO;
        end
      end

      WAIT_HIGH: begin
        if (!s) begin
          // Reversal: no partial credit, start again from the stable low.
          state_d = IDLE_LOW;
          c_d     = CNT_ZERO;
        end else if (c_q == STABLE_LAST) begin
          // c stays at its terminal value here rather than wrapping.
          state_d = IDLE_HIGH;
          level_d = 1'b1;
          pulse_d = 1'b1;
        end else begin
          c_d = c_q + CNT_ONE;
        end
      end

      IDLE_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          c_d     = CNT_ZERO;
        end
`ifdef AUTO_REPEAT_EN
        else if (r_q == REPEAT_LAST) begin
          pulse_d = 1'b1;
          r_d     = CNT_ZERO;
        end else begin
          r_d = r_q + CNT_ONE;
        end
`endif
      end

      WAIT_LOW: begin
        if (s) begin
          // Release aborted: back to the held state, repeat restarts from 0.
          state_d = IDLE_HIGH;
          c_d     = CNT_ZERO;
        end else if (c_q == STABLE_LAST) begin
          state_d = IDLE_LOW;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          c_d = c_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE_LOW;
        c_d     = CNT_ZERO;
        level_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign level = level_q;
  assign pulse = pulse_q;
  assign rel   = rel_q;
  assign busy  = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);

  // ---------------------------------------------------------------------------
  // Embedded properties
  // ---------------------------------------------------------------------------
  // Parameter legality; a violation shows up on the first clock after reset.
  a_params_ok : assert property (@(posedge clk) disable iff (!rst) PARAMS_OK);

  // Press and release strobes are mutually exclusive.
  a_pulse_rel_excl : assert property (@(posedge clk) disable iff (!rst)
                                      !(pulse_q && rel_q));

  // Neither strobe is ever asserted in two consecutive cycles.
  a_pulse_single : assert property (@(posedge clk) disable iff (!rst)
                                    !(pulse_q && pulse_d));
  a_rel_single : assert property (@(posedge clk) disable iff (!rst)
                                  !(rel_q && rel_d));

endmodule

// File: tb/tb_debounce_pulse.sv
// -----------------------------------------------------------------------------
// tb_debounce_pulse
//
// Directed bench for debounce_pulse with default parameters. Inputs are driven
// and outputs sampled on the falling clock edge. `cyc` counts falling edges
// since the last stimulus change of interest: with din changed at cyc=0, the
// next rising edge is E0 and outputs updated by edge En are seen at cyc=n+1.
// The tick task also acts as the downstream event counter (pulse_cnt) and
// records when the last pulse / rel was seen.
// -----------------------------------------------------------------------------
module tb_debounce_pulse;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0;
  logic level;
  logic pulse;
  logic rel;
  logic busy;

  int n_checks  = 0;
  int n_pass    = 0;
  int cyc       = 0;
  int pulse_cnt = 0;
  int rel_cnt   = 0;
  int pulse_cyc = -1;
  int rel_cyc   = -1;
  int overlap   = 0;

  debounce_pulse #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(16),
    .CNT_BITS     (8),
    .REPEAT_CYCLES(64)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .level(level),
    .pulse(pulse),
    .rel  (rel),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one falling edge and update the pulse/rel bookkeeping.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (pulse === 1'b1) begin
      pulse_cnt++;
      pulse_cyc = cyc;
    end
    if (rel === 1'b1) begin
      rel_cnt++;
      rel_cyc = cyc;
    end
    if (pulse === 1'b1 && rel === 1'b1) overlap++;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic restart();
    cyc       = 0;
    pulse_cnt = 0;
    rel_cnt   = 0;
    pulse_cyc = -1;
    rel_cyc   = -1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    tick_n(3);
    check("rst_level", int'(level), 0);
    check("rst_pulse", int'(pulse), 0);
    check("rst_rel",   int'(rel),   0);
    check("rst_busy",  int'(busy),  0);
    rst = 1'b1;
    tick_n(3);

    // ---------------- clean press ----------------
    din = 1'b1;
    restart();
    tick_n(2);
    check("press_busy_e1", int'(busy), 0);
    tick();
    check("press_busy_e2", int'(busy), 1);
    tick_n(15);                                  // cyc = 18 -> after E17
    check("press_busy_e17",  int'(busy),  1);
    check("press_level_e17", int'(level), 0);
    check("press_pulse_e17", int'(pulse), 0);
    tick();                                      // cyc = 19 -> after E18
    check("press_level_e18", int'(level), 1);
    check("press_pulse_e18", int'(pulse), 1);
    check("press_busy_e18",  int'(busy),  0);
    tick();
    check("press_pulse_e19", int'(pulse), 0);
    tick_n(40);                                  // cyc = 60
    check("press_pulse_cnt", pulse_cnt, 1);
    check("press_level_held", int'(level), 1);

    // ---------------- short low glitch while high ----------------
    din = 1'b0;
    restart();
    tick_n(3);
    check("lglitch_busy", int'(busy), 1);
    tick_n(2);
    din = 1'b1;
    tick_n(30);
    check("lglitch_rel_cnt", rel_cnt, 0);
    check("lglitch_level",   int'(level), 1);
    check("lglitch_busy_end", int'(busy), 0);

    // ---------------- release ----------------
    din = 1'b0;
    restart();
    tick_n(18);
    check("rel_level_e17", int'(level), 1);
    check("rel_rel_e17",   int'(rel),   0);
    tick();
    check("rel_rel_e18",   int'(rel),   1);
    check("rel_level_e18", int'(level), 0);
    tick();
    check("rel_rel_e19",   int'(rel),   0);
    tick_n(20);                                  // cyc = 40
    check("rel_rel_cnt",   rel_cnt,   1);
    check("rel_pulse_cnt", pulse_cnt, 0);

    // ---------------- high glitch (10 cycles) ----------------
    din = 1'b1;
    restart();
    tick_n(5);
    check("hglitch_busy", int'(busy), 1);
    tick_n(5);
    din = 1'b0;
    tick_n(30);
    check("hglitch_pulse_cnt", pulse_cnt, 0);
    check("hglitch_level",     int'(level), 0);
    check("hglitch_busy_end",  int'(busy),  0);

    // ---------------- bounce then hold ----------------
    restart();
    for (int seg = 0; seg < 8; seg++) begin
      din = ((seg % 2) == 0) ? 1'b1 : 1'b0;
      tick_n(3);
    end
    din = 1'b1;                                  // final rise at cyc = 24
    tick_n(46);                                  // cyc = 70
    check("bounce_pulse_cnt", pulse_cnt, 1);
    check("bounce_pulse_cyc", pulse_cyc, 43);
    check("bounce_level",     int'(level), 1);
    din = 1'b0;
    tick_n(25);
    check("bounce_rel_level", int'(level), 0);

    // ---------------- reset mid-qualify, din low at release ----------------
    din = 1'b1;
    restart();
    tick_n(11);                                  // c = 8 in WAIT_HIGH
    check("mid_busy_before", int'(busy), 1);
    rst = 1'b0;
    #1;
    check("mid_async_busy",  int'(busy),  0);
    check("mid_async_level", int'(level), 0);
    check("mid_async_pulse", int'(pulse), 0);
    din = 1'b0;
    tick_n(2);
    rst = 1'b1;
    restart();
    tick_n(30);
    check("mid_low_pulse_cnt", pulse_cnt, 0);
    check("mid_low_level",     int'(level), 0);

    // ---------------- reset mid-qualify, din high at release ----------------
    din = 1'b1;
    restart();
    tick_n(11);
    rst = 1'b0;
    #1;
    check("mid2_async_busy", int'(busy), 0);
    tick_n(2);
    rst = 1'b1;
    restart();
    tick_n(40);
    check("mid_high_pulse_cnt", pulse_cnt, 1);
    check("mid_high_pulse_cyc", pulse_cyc, 19);

    // ---------------- long hold (auto-repeat when built in) ----------------
    din = 1'b0;
    tick_n(25);
    check("hold_pre_level", int'(level), 0);
    din = 1'b1;
    restart();
    tick_n(219);                                 // 200 cycles past level rise
`ifdef AUTO_REPEAT_EN
    check("hold_pulse_cnt", pulse_cnt, 4);
    check("hold_last_pulse_cyc", pulse_cyc, 211);
`else
    check("hold_pulse_cnt", pulse_cnt, 1);
    check("hold_last_pulse_cyc", pulse_cyc, 19);
`endif
    check("hold_level", int'(level), 1);
    check("pulse_rel_overlap", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
